// File: rtl/mult_share_arbiter_pkg.sv
// Package for the shared-multiplier arbiter slice.
// - id_width(): bit width needed to index a requester (minimum 1).
// - mul_req_t : operand/id bundle for the default configuration.
// - RESET_ID  : requester id held by S1/S2 after reset.
package mult_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_WIDTH = 16;
  localparam int DEF_B_WIDTH = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);
  localparam int RESET_ID = 0;

  typedef struct packed {
    logic signed [DEF_A_WIDTH-1:0] a;
    logic signed [DEF_B_WIDTH-1:0] b;
    logic        [DEF_ID_W-1:0]    id;
  } mul_req_t;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin arbiter with its own priority pointer.
// Ports:
//   clk, rst_n : clock, async active-low reset (rr_ptr -> 0)
//   req        : per-requester request
//   advance    : the current grant was accepted this cycle
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : binary index of the winner
//   ptr        : current highest-priority requester
// The pointer only moves past a grant that was actually taken, so stalled
// or idle cycles never rotate priority.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic [ID_W-1:0]    ptr
);

  logic [ID_W-1:0] rr_ptr;

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Scan upward from rr_ptr, wrapping at NUM_REQ-1 back to 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign ptr = rr_ptr;

endmodule

// File: rtl/multiplier.sv
// Signed multiplier with fixed arithmetic right shift.
// Ports:
//   a, b : signed operands
//   p    : (a*b) >>> OUT_SCALE, truncated / sign-extended to OUT_WIDTH
// Purely combinational; the caller registers both operands and the result.
module multiplier #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int OUT_SCALE = 16
) (
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [OUT_WIDTH-1:0] p
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  assign prod    = PW'(a) * PW'(b);
  assign shifted = prod >>> OUT_SCALE;
  assign p       = OUT_WIDTH'(shifted);

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier between NUM_REQ requesters.
// Ports:
//   clk, arst_n_in       : clock, async active-low reset
//   req_valid/req_ready  : per-requester handshake, req_ready one-hot or zero
//   req_a, req_b         : packed operands, requester i at slice i
//   res_valid/res_ready  : result handshake with backpressure
//   res_data, res_id     : (a*b)>>>OUT_SCALE and the owning requester
// Handshake rule (both buses): a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload while valid.
// Pipeline: S1 = operand/id registers feeding the multiplier, S2 = result
// registers. S1 may refill in the same cycle S2 drains, so no bubble.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int OUT_SCALE = 16,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [OUT_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]              res_id
);

  typedef struct packed {
    logic signed [A_WIDTH-1:0] a;
    logic signed [B_WIDTH-1:0] b;
    logic        [ID_W-1:0]    id;
  } s1_t;

  s1_t                        s1_q;
  logic                       s1_valid;
  logic                       s2_advance;
  logic                       s1_accept;
  logic                       accept;
  logic [NUM_REQ-1:0]         grant;
  logic [ID_W-1:0]            grant_idx;
  logic [ID_W-1:0]            rr_ptr;
  logic signed [OUT_WIDTH-1:0] mul_p;

  assign s2_advance = !res_valid || res_ready;
  assign s1_accept  = !s1_valid || s2_advance;

  // Reset is folded in so req_ready drops the moment reset asserts.
  assign req_ready = grant & {NUM_REQ{s1_accept & arst_n_in}};
  assign accept    = |req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (arst_n_in),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (rr_ptr)
  );

  multiplier #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SCALE (OUT_SCALE)
  ) u_mul (
    .a (s1_q.a),
    .b (s1_q.b),
    .p (mul_p)
  );

  // S1: operand registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q.a   <= req_a[grant_idx*A_WIDTH +: A_WIDTH];
      s1_q.b   <= req_b[grant_idx*B_WIDTH +: B_WIDTH];
      s1_q.id  <= grant_idx;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: result registers; frozen while the consumer stalls.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= ID_W'(RESET_ID);
    end else if (s1_valid && s2_advance) begin
      res_valid <= 1'b1;
      res_data  <= mul_p;
      res_id    <= s1_q.id;
    end else if (s2_advance) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_share_arbiter dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // Requester i gets a=(i+1)<<8, b=0x0100, so the result is i+1.
  task automatic load_ramp();
    for (int i = 0; i < 4; i++) set_op(i, 16'((i + 1) << 8), 16'h0100);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    arst_n_in = 1'b0;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    #1;
  endtask

  task automatic chk_res(input string name, input logic v, input logic [1:0] id,
                         input logic [31:0] d);
    // Inline comparisons for one result beat.
    n_vec++;
    if (res_valid !== v) begin
      n_err++;
      $display("FAIL %s res_valid: got %b exp %b", name, res_valid, v);
    end
    if (v) begin
      n_vec++;
      if (res_id !== id || res_data !== d) begin
        n_err++;
        $display("FAIL %s result: got id=%0d data=%h exp id=%0d data=%h",
                 name, res_id, res_data, id, d);
      end
    end
  endtask

  task automatic chk_ready(input string name, input logic [3:0] exp);
    n_vec++;
    if (req_ready !== exp) begin
      n_err++;
      $display("FAIL %s req_ready: got %b exp %b", name, req_ready, exp);
    end
  endtask

  task automatic chk_ptr(input string name, input logic [1:0] exp);
    n_vec++;
    if (dut.u_arb.rr_ptr !== exp) begin
      n_err++;
      $display("FAIL %s rr_ptr: got %0d exp %0d", name, dut.u_arb.rr_ptr, exp);
    end
  endtask

  // One isolated transaction through an idle pipeline.
  task automatic do_one(input string name, input int i, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    set_op(i, a, b);
    req_valid = 4'(1 << i);
    #1;
    chk_ready(name, 4'(1 << i));
    tick();
    req_valid = 4'b0000;
    chk_res(name, 1'b0, 2'd0, 32'd0);
    tick();
    chk_res(name, 1'b1, 2'(i), exp);
    tick();
    chk_res(name, 1'b0, 2'd0, 32'd0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_n_in = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    #2;
    chk_res("reset", 1'b0, 2'd0, 32'd0);
    n_vec++;
    if (res_data !== 32'd0 || res_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset outputs: got data=%h id=%0d exp 0/0", res_data, res_id);
    end
    chk_ready("reset gated", 4'b0000);
    tick();
    chk_ready("reset held", 4'b0000);
    arst_n_in = 1'b1;
    #1;
    chk_ready("reset release", 4'b0001);
    chk_ptr("reset", 2'd0);
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_single();
    do_one("single", 0, 16'h4000, 16'h4000, 32'h0000_1000);
  endtask

  task automatic test_sign();
    do_one("sign neg*neg", 2, 16'hFFFE, 16'h8000, 32'h0000_0001);
    do_one("sign floor",   3, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
    do_one("sign max",     1, 16'h7FFF, 16'h7FFF, 32'h0000_3FFF);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    load_ramp();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk_ready("b2b grant", 4'(1 << (c % 4)));
      tick();
      if (c >= 1) chk_res("b2b", 1'b1, 2'((c - 1) % 4), 32'(((c - 1) % 4) + 1));
    end
    req_valid = 4'b0000;
    tick();
    chk_res("b2b last", 1'b1, 2'd3, 32'd4);
    tick();
    chk_res("b2b empty", 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_rr_skip();
    apply_reset();
    res_ready = 1'b1;
    do_one("skip setup", 1, 16'h0100, 16'h0100, 32'h0000_0001);
    chk_ptr("skip setup", 2'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_ptr("skip idle", 2'd2);
    end
    set_op(3, 16'h0300, 16'h0100);
    set_op(1, 16'hFF00, 16'h0200);
    req_valid = 4'b1010;
    #1;
    chk_ready("skip first", 4'b1000);
    tick();
    chk_res("skip", 1'b0, 2'd0, 32'd0);
    req_valid = 4'b0010;
    #1;
    chk_ready("skip second", 4'b0010);
    tick();
    req_valid = 4'b0000;
    chk_res("skip r3", 1'b1, 2'd3, 32'h0000_0003);
    tick();
    chk_res("skip r1", 1'b1, 2'd1, 32'hFFFF_FFFE);
    tick();
    chk_res("skip end", 1'b0, 2'd0, 32'd0);
    chk_ptr("skip end", 2'd2);
  endtask

  task automatic test_stall();
    // rr_ptr is 2 on entry.
    load_ramp();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_ready("stall g2", 4'b0100);
    tick();
    chk_res("stall s1", 1'b0, 2'd0, 32'd0);
    chk_ready("stall g3", 4'b1000);
    tick();
    chk_res("stall hold", 1'b1, 2'd2, 32'd3);
    chk_ready("stall full", 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_res("stall hold", 1'b1, 2'd2, 32'd3);
      chk_ready("stall full", 4'b0000);
    end
    res_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    chk_res("stall drain", 1'b1, 2'd3, 32'd4);
    tick();
    chk_res("stall empty", 1'b0, 2'd0, 32'd0);
    chk_ptr("stall", 2'd0);
  endtask

  task automatic test_reset_mid();
    load_ramp();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    chk_res("mid inflight", 1'b1, 2'd0, 32'd1);
    arst_n_in = 1'b0;
    #1;
    chk_res("mid reset", 1'b0, 2'd0, 32'd0);
    n_vec++;
    if (res_data !== 32'd0 || res_id !== 2'd0) begin
      n_err++;
      $display("FAIL mid reset outputs: got data=%h id=%0d exp 0/0", res_data, res_id);
    end
    chk_ready("mid reset", 4'b0000);
    req_valid = 4'b0000;
    tick();
    tick();
    arst_n_in = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_res("mid no stale", 1'b0, 2'd0, 32'd0);
    end
    chk_ptr("mid", 2'd0);
    req_valid = 4'b1111;
    #1;
    chk_ready("mid regrant", 4'b0001);
    req_valid = 4'b0000;
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_back_to_back();
    test_rr_skip();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
